// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts rising edges of an asynchronous DCO output over a fixed window of
// GATE_CYCLES clk cycles. It reports the result under a start/valid/ack handshake.
//
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous reset, active low
//   ena_i       block enable; low aborts any measurement in progress
//   dco_in_i    DCO output, asynchronous to clk_i
//   start_i     measurement request (honoured in idle, or in done together with ack_i)
//   ack_i       consumer accepts the current result
//   busy_o      arming or measuring
//   valid_o     result available, held until ack_i
//   count_o     rising edges counted in the gate window (saturating)
//   overflow_o  count saturated during the last measurement
//   period_o    clk cycles between the last two counted rises
//
// Optional feature: define DCO_METER_PERIOD_EN to build the interval counter behind period_o.
// Without it, period_o is tied to zero.
module dco_freq_meter #(
  parameter int unsigned GATE_CYCLES = 256,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PER_W       = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             dco_in_i,
  input  logic             start_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic [PER_W-1:0] period_o
);

  localparam int unsigned      GateW    = $clog2(GATE_CYCLES + 1);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;
  logic [GateW-1:0]       gate_q, gate_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d, edge_next;
  logic                   ovf_run_q, ovf_run_d, ovf_next;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  // The synchroniser runs every cycle so that the edge detector is already settled when arming.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dco_in_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Saturating edge count; a rise arriving at the ceiling marks overflow.
  assign edge_next = (edge_cnt_q == CntMax) ? edge_cnt_q : edge_cnt_q + CNT_W'(1);
  assign ovf_next  = ovf_run_q | (edge_cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    ovf_run_d  = ovf_run_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (start_i && ena_i) begin
          state_d = StArm;
          gate_d  = '0;
        end
      end
      StArm: begin
        if (!ena_i) begin
          state_d = StIdle;
        end else if (rise) begin
          // Arming edge: opens the window but is not counted.
          state_d    = StMeasure;
          gate_d     = '0;
          edge_cnt_d = '0;
          ovf_run_d  = 1'b0;
        end else if (gate_q == GateLast) begin
          // Stopped DCO: report an empty measurement.
          state_d    = StDone;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          gate_d = gate_q + GateW'(1);
        end
      end
      StMeasure: begin
        if (!ena_i) begin
          state_d = StIdle;
        end else begin
          if (rise) begin
            edge_cnt_d = edge_next;
            ovf_run_d  = ovf_next;
          end
          if (gate_q == GateLast) begin
            // A rise on the final window cycle still counts.
            state_d    = StDone;
            count_d    = rise ? edge_next : edge_cnt_q;
            overflow_d = rise ? ovf_next : ovf_run_q;
          end else begin
            gate_d = gate_q + GateW'(1);
          end
        end
      end
      StDone: begin
        if (!ena_i) begin
          state_d = StIdle;
        end else if (ack_i) begin
          state_d = (start_i) ? StArm : StIdle;
          gate_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      ovf_run_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_run_q  <= ovf_run_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o     = (state_q == StArm) || (state_q == StMeasure);
  assign valid_o    = (state_q == StDone);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

`ifdef DCO_METER_PERIOD_EN
  localparam logic [PER_W-1:0] PerMax = '1;

  logic             arm_hit, meas_rise, meas_end, arm_timeout;
  logic [PER_W-1:0] interval_q, interval_inc, last_per_q, period_q;

  assign arm_hit     = (state_q == StArm) && ena_i && rise;
  assign arm_timeout = (state_q == StArm) && ena_i && !rise && (gate_q == GateLast);
  assign meas_rise   = (state_q == StMeasure) && ena_i && rise;
  assign meas_end    = (state_q == StMeasure) && ena_i && (gate_q == GateLast);

  // interval_q holds cycles elapsed minus one, so the value latched on a rise is the full
  // distance from the previous restart.
  assign interval_inc = (interval_q == PerMax) ? interval_q : interval_q + PER_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      interval_q <= '0;
      last_per_q <= '0;
      period_q   <= '0;
    end else begin
      if (arm_hit) begin
        interval_q <= '0;
        last_per_q <= '0;
      end else if (state_q == StMeasure) begin
        if (meas_rise) begin
          last_per_q <= interval_inc;
          interval_q <= '0;
        end else begin
          interval_q <= interval_inc;
        end
      end
      if (meas_end) begin
        period_q <= meas_rise ? interval_inc : last_per_q;
      end else if (arm_timeout) begin
        period_q <= '0;
      end
    end
  end

  assign period_o = period_q;
`else
  assign period_o = '0;
`endif

endmodule

// File: tb/tb_dco_freq_meter.sv
module tb_dco_freq_meter;

  localparam int unsigned G = 256;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, dco = 1'b0, start = 1'b0, ack = 1'b0;
  logic       busy8, valid8, ovf8, busy4, valid4, ovf4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;
  logic [8:0] per8, per4;

  dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2), .PER_W(9)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .dco_in_i(dco), .start_i(start), .ack_i(ack),
    .busy_o(busy8), .valid_o(valid8), .count_o(cnt8), .overflow_o(ovf8), .period_o(per8)
  );

  dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2), .PER_W(9)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .dco_in_i(dco), .start_i(start), .ack_i(ack),
    .busy_o(busy4), .valid_o(valid4), .count_o(cnt4), .overflow_o(ovf4), .period_o(per4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit          ovf;
    int unsigned per;
  } res_t;

  res_t        q8[$], q4[$];
  res_t        last8, last4;
  int unsigned n_vec = 0, n_bad = 0;
  int unsigned dco_p = 0, dco_h = 0, dco_gen = 0;

  // DCO waveform: period dco_p clk cycles, high for the last dco_h of each period; p=0 holds low.
  initial begin
    int unsigned ph, seen;
    ph = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      if (dco_gen != seen) begin
        seen = dco_gen;
        ph   = 0;
        dco  = 1'b0;
      end else if (dco_p == 0) begin
        dco = 1'b0;
      end else begin
        ph  = ph + 1;
        dco = ((ph % dco_p) >= (dco_p - dco_h));
      end
    end
  end

  // Reference: a periodic DCO gives floor(G/p) rises after the arming edge inside the window.
  function automatic res_t model(int unsigned p, int unsigned cw);
    res_t        r;
    int unsigned c, mx;
    c     = (p == 0 || p > G) ? 0 : G / p;
    mx    = (1 << cw) - 1;
    r.cnt = (c > mx) ? mx : c;
    r.ovf = (c > mx);
`ifdef DCO_METER_PERIOD_EN
    r.per = (c > 0) ? p : 0;
`else
    r.per = 0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_dco(input int unsigned p, input int unsigned h);
    dco_p = p;
    dco_h = h;
    dco_gen++;
  endtask

  task automatic push_exp(input int unsigned p);
    last8 = model(p, 8);
    last4 = model(p, 4);
    q8.push_back(last8);
    q4.push_back(last4);
  endtask

  // Waits for valid; pulses start mid-measurement, which must be ignored.
  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      start = (i == 30);
      if (valid8) got = 1'b1;
    end
    start = 1'b0;
    if (!got) check("valid_timeout", 0, 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("valid_after_ack", valid8, 0);
  endtask

  task automatic run_measure(input int unsigned p, input int unsigned h);
    set_dco(p, h);
    repeat (8) tick();
    start = 1'b1;
    push_exp(p);
    tick();
    start = 1'b0;
    wait_valid();
    do_ack();
  endtask

  // Monitor: pops one expectation per rising edge of valid on each instance.
  initial begin
    bit   pv8, pv4;
    res_t e;
    pv8 = 1'b0;
    pv4 = 1'b0;
    forever begin
      @(negedge clk);
      if (valid8 && !pv8) begin
        if (q8.size() == 0) begin
          check("unexpected_valid8", 1, 0);
        end else begin
          e = q8.pop_front();
          check("count8", cnt8, e.cnt);
          check("overflow8", ovf8, e.ovf);
          check("period8", per8, e.per);
        end
      end
      if (valid4 && !pv4) begin
        if (q4.size() == 0) begin
          check("unexpected_valid4", 1, 0);
        end else begin
          e = q4.pop_front();
          check("count4", cnt4, e.cnt);
          check("overflow4", ovf4, e.ovf);
          check("period4", per4, e.per);
        end
      end
      pv8 = valid8;
      pv4 = valid4;
    end
  end

  initial begin
    int unsigned p, h;
    // Reset with the DCO toggling.
    set_dco(4, 2);
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy8, 0);
    check("rst_valid", valid8, 0);
    check("rst_count", cnt8, 0);
    check("rst_overflow", ovf8, 0);
    check("rst_period", per8, 0);
    check("rst_count4", cnt4, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    run_measure(22, 11);   // 11 rises, period 22
    run_measure(8, 4);     // 32 rises; 4-bit instance saturates
    run_measure(256, 100); // single rise on the last window cycle
    run_measure(257, 100); // no rise after arming inside the window
    run_measure(0, 0);     // stopped DCO: arm timeout

    // Back-to-back: ack and start together.
    set_dco(22, 11);
    repeat (8) tick();
    start = 1'b1;
    push_exp(22);
    tick();
    start = 1'b0;
    wait_valid();
    ack   = 1'b1;
    start = 1'b1;
    push_exp(22);
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("b2b_valid_low", valid8, 0);
    check("b2b_busy", busy8, 1);
    wait_valid();
    do_ack();

    // Abort by dropping ena mid-measurement; no result may appear.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("abort_busy_pre", busy8, 1);
    ena = 1'b0;
    tick();
    check("abort_busy", busy8, 0);
    check("abort_valid", valid8, 0);
    check("abort_count8", cnt8, last8.cnt);
    check("abort_count4", cnt4, last4.cnt);
    check("abort_period8", per8, last8.per);
    ena = 1'b1;
    repeat (400) tick();

    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(300, 2);
      h = $urandom_range(p - 1, 1);
      run_measure(p, h);
    end

    // Reset mid-measurement discards everything.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy8, 0);
    check("midrst_count", cnt8, 0);
    check("midrst_period", per8, 0);
    rst_n = 1'b1;
    run_measure(8, 3);

    repeat (5) tick();
    check("leftover_q8", q8.size(), 0);
    check("leftover_q4", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
